current_sense_adc: RTL and testbench

- SPI master for the motor-current ADC (12-bit, AD7476-style 16-clock frame) on pins CS, CS_CLK and CS_MISO.
- Runs conversions periodically and averages 2^AVG_LOG2 samples.
- Subtracts a calibratable zero-current offset and produces the signed 13-bit `current` word consumed by the coms block for telemetry.
- Sits between the board's current-sense ADC pins and coms, in the 32 MHz PLL domain.

---
 rtl/current_sense_adc_if.sv | 9 +
 rtl/current_sense_adc.sv | 148 ++++++++++++++
 tb/tb_current_sense_adc.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/current_sense_adc_if.sv
// Pin-level SPI bundle between the current-sense ADC master and the ADC.
interface current_sense_adc_if;
   logic CS;
   logic CS_CLK;
   logic CS_MISO;

   modport master (output CS, output CS_CLK, input CS_MISO);
   modport slave  (input CS, input CS_CLK, output CS_MISO);
endinterface

// File: rtl/current_sense_adc.sv
// Periodic 16-clock SPI reads of the motor-current ADC, averaged over
// 2^AVG_LOG2 samples, offset-corrected into a signed 13-bit telemetry word.
module current_sense_adc #(
   parameter int CLK_DIV        = 8,
   parameter int SAMPLE_PERIOD  = 3200,
   parameter int AVG_LOG2       = 2,
   parameter int OFFSET_DEFAULT = 2048
) (
   input  logic                     CLK,
   input  logic                     reset_n,
   input  logic                     calibrate,
   current_sense_adc_if.master      spi,
   output logic [11:0]              raw,
   output logic signed [12:0]       current,
   output logic                     current_valid,
   output logic                     frame_error
);
   localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int TW  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int AW  = 12 + AVG_LOG2;
   localparam int NW  = AVG_LOG2 + 1;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, QUIET, UPDATE} state_t;
   state_t state, state_nxt;

   logic [DW-1:0] div;
   logic [3:0]    bit_idx;
   logic          hi;
   logic [15:0]   shreg;
   logic [TW-1:0] timer;
   logic          pending;
   logic          tick, start, div_end, last;
   logic [AW-1:0] acc, acc_sum;
   logic [NW-1:0] cnt;
   logic [11:0]   avg_r, offset;
   logic          cal_armed;
   logic [1:0]    vld_pipe;
   logic          cs_q, sclk_q;

   assign tick    = (timer == TW'(SAMPLE_PERIOD - 1));
   assign start   = (state == IDLE) && (tick || pending);
   assign div_end = (div == DW'(CLK_DIV - 1));
   assign last    = (cnt == NW'((1 << AVG_LOG2) - 1));
   assign acc_sum = acc + AW'(shreg[11:0]);

   always_ff @(posedge CLK or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;

   always_comb begin
      state_nxt = state;
      cs_q      = 1'b1;
      sclk_q    = 1'b1;
      case (state)
         IDLE:   if (start) state_nxt = SETUP;
         SETUP:  begin
            cs_q = 1'b0;
            if (div_end) state_nxt = SHIFT;
         end
         SHIFT:  begin
            cs_q   = 1'b0;
            sclk_q = hi;
            if (div_end && hi && bit_idx == 4'd15) state_nxt = QUIET;
         end
         QUIET:  if (div_end) state_nxt = UPDATE;
         UPDATE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign spi.CS     = cs_q;
   assign spi.CS_CLK = sclk_q;

   // Ticks arriving mid-frame collapse into a single pending start.
   always_ff @(posedge CLK or negedge reset_n)
      if (!reset_n) begin
         timer   <= '0;
         pending <= 1'b0;
      end else begin
         timer <= tick ? '0 : timer + 1'b1;
         if (start)                        pending <= 1'b0;
         else if (tick && state != IDLE)   pending <= 1'b1;
      end

   // MISO is captured on the edge that takes CS_CLK high.
   always_ff @(posedge CLK or negedge reset_n)
      if (!reset_n) begin
         div     <= '0;
         bit_idx <= '0;
         hi      <= 1'b0;
         shreg   <= '0;
      end else begin
         if (state == SETUP || state == SHIFT || state == QUIET)
            div <= div_end ? '0 : div + 1'b1;
         else
            div <= '0;
         if (state == SETUP) begin
            bit_idx <= '0;
            hi      <= 1'b0;
         end else if (state == SHIFT && div_end) begin
            if (!hi) begin
               shreg <= {shreg[14:0], spi.CS_MISO};
               hi    <= 1'b1;
            end else begin
               hi      <= 1'b0;
               bit_idx <= bit_idx + 1'b1;
            end
         end
      end

   always_ff @(posedge CLK or negedge reset_n)
      if (!reset_n) begin
         raw           <= '0;
         frame_error   <= 1'b0;
         acc           <= '0;
         cnt           <= '0;
         avg_r         <= '0;
         offset        <= 12'(OFFSET_DEFAULT);
         cal_armed     <= 1'b0;
         vld_pipe      <= '0;
         current       <= '0;
      end else begin
         vld_pipe <= {vld_pipe[0], 1'b0};
         if (calibrate) cal_armed <= 1'b1;
         if (state == UPDATE) begin
            raw <= shreg[11:0];
            if (|shreg[15:12]) frame_error <= 1'b1;
            if (last) begin
               avg_r       <= acc_sum[AW-1:AVG_LOG2];
               acc         <= '0;
               cnt         <= '0;
               vld_pipe[0] <= 1'b1;
               // The calibrating average also reports against itself, i.e. zero.
               if (cal_armed) begin
                  offset    <= acc_sum[AW-1:AVG_LOG2];
                  cal_armed <= 1'b0;
               end
            end else begin
               acc <= acc_sum;
               cnt <= cnt + 1'b1;
            end
         end
         if (vld_pipe[0])
            current <= $signed({1'b0, avg_r}) - $signed({1'b0, offset});
      end

   assign current_valid = vld_pipe[1];
endmodule

// File: tb/tb_current_sense_adc.sv
// Directed bench: behavioural ADC on the SPI pins, hand-computed expectations.
module tb_current_sense_adc;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic calibrate = 1'b0;
   logic [11:0] raw;
   logic signed [12:0] current;
   logic current_valid, frame_error;

   int n_vec = 0;
   int n_err = 0;

   current_sense_adc_if spi_if ();

   current_sense_adc #(.CLK_DIV(8), .SAMPLE_PERIOD(288), .AVG_LOG2(2), .OFFSET_DEFAULT(2048)) dut (
      .CLK(clk), .reset_n(reset_n), .calibrate(calibrate), .spi(spi_if),
      .raw(raw), .current(current), .current_valid(current_valid), .frame_error(frame_error)
   );

   always #5 clk = ~clk;

   // ADC model: word chosen at CS fall, one bit presented per SCLK falling edge.
   logic [15:0] adc_word = 16'h0800;
   logic [15:0] adc_q[$];
   logic [15:0] adc_sh = '0;
   initial spi_if.CS_MISO = 1'b0;
   always @(negedge spi_if.CS or negedge spi_if.CS_CLK) begin
      if (spi_if.CS_CLK === 1'b1) begin
         adc_sh = (adc_q.size() > 0) ? adc_q.pop_front() : adc_word;
      end else if (spi_if.CS === 1'b0) begin
         spi_if.CS_MISO = adc_sh[15];
         adc_sh = {adc_sh[14:0], 1'b0};
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_cs(input logic lvl, input int maxc, output int n);
      n = 0;
      while (spi_if.CS !== lvl && n < maxc) begin
         @(negedge clk);
         n++;
      end
      if (spi_if.CS !== lvl) chk("cs_timeout", 0, 1);
   endtask

   task automatic wait_valid(input int maxc, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!current_valid && n < maxc);
      if (!current_valid) chk("valid_timeout", 0, 1);
   endtask

   task automatic skip(input int k);
      repeat (k) @(negedge clk);
   endtask

   initial begin
      int n, lo, gap, rises, low1, run;
      logic prev;

      // reset state
      skip(3);
      chk("rst_cs", int'(spi_if.CS), 1);
      chk("rst_sclk", int'(spi_if.CS_CLK), 1);
      chk("rst_raw", int'(raw), 0);
      chk("rst_current", int'(current), 0);
      chk("rst_valid", int'(current_valid), 0);
      chk("rst_ferr", int'(frame_error), 0);
      reset_n = 1'b1;

      // first frame: start on timer wrap, 16 SCLK rises, 8-cycle half periods
      wait_cs(1'b0, 400, n);
      chk("first_start", n, 288);
      lo = 1; rises = 0; low1 = 0; run = 0; prev = 1'b1;
      while (spi_if.CS === 1'b0 && lo < 400) begin
         @(negedge clk);
         if (spi_if.CS_CLK === 1'b1 && prev === 1'b0) rises++;
         if (spi_if.CS_CLK === 1'b0) run++;
         else if (run != 0 && low1 == 0) low1 = run;
         prev = spi_if.CS_CLK;
         if (spi_if.CS === 1'b0) lo++;
      end
      chk("cs_low_len", lo, 264);
      chk("sclk_rises", rises, 16);
      chk("sclk_low_half", low1, 8);
      chk("sclk_idle_after", int'(spi_if.CS_CLK), 1);
      skip(12);
      chk("raw_800", int'(raw), 12'h800);

      // mid-scale input with default offset
      wait_valid(2000, n);
      chk("cur_mid", int'(current), 0);
      skip(1);
      chk("valid_single", int'(current_valid), 0);
      wait_valid(2000, n);
      chk("valid_period", n + 1, 1152);

      adc_q.push_back(16'd3000); adc_q.push_back(16'd3002);
      adc_q.push_back(16'd3004); adc_q.push_back(16'd3006);
      wait_valid(2000, n);
      chk("cur_3003", int'(current), 955);
      repeat (4) adc_q.push_back(16'd100);
      wait_valid(2000, n);
      chk("cur_100", int'(current), -1948);

      // calibration
      adc_word = 16'd2100;
      wait_valid(2000, n);
      chk("cur_2100_pre", int'(current), 52);
      calibrate = 1'b1;
      @(negedge clk);
      calibrate = 1'b0;
      wait_valid(2000, n);
      chk("cur_cal_zero", int'(current), 0);
      adc_word = 16'd2110;
      wait_valid(2000, n);
      chk("cur_plus10", int'(current), 10);
      wait_valid(2000, n);
      chk("cur_plus10_again", int'(current), 10);

      // leading-bit error, sample still used, flag sticky
      chk("ferr_clear", int'(frame_error), 0);
      adc_word = 16'h0100;
      adc_q.push_back(16'h2123);
      wait_cs(1'b0, 400, n);
      wait_cs(1'b1, 400, n);
      skip(12);
      chk("raw_123", int'(raw), 12'h123);
      chk("ferr_set", int'(frame_error), 1);
      wait_cs(1'b0, 400, n);
      wait_cs(1'b1, 400, n);
      skip(12);
      chk("raw_100", int'(raw), 12'h100);
      chk("ferr_sticky", int'(frame_error), 1);

      // reset at 7th SCLK rise aborts the frame and clears averaging
      wait_cs(1'b0, 400, n);
      rises = 0; prev = 1'b1; n = 0;
      while (rises < 7 && n < 400) begin
         @(negedge clk);
         n++;
         if (spi_if.CS_CLK === 1'b1 && prev === 1'b0) rises++;
         prev = spi_if.CS_CLK;
      end
      chk("seventh_rise", rises, 7);
      reset_n = 1'b0;
      #1;
      chk("abort_cs", int'(spi_if.CS), 1);
      chk("abort_sclk", int'(spi_if.CS_CLK), 1);
      chk("abort_ferr", int'(frame_error), 0);
      adc_word = 16'hFFFF;
      skip(3);
      reset_n = 1'b1;
      rises = 0; prev = 1'b1; n = 0;
      while (!current_valid && n < 2000) begin
         @(negedge clk);
         n++;
         if (spi_if.CS === 1'b1 && prev === 1'b0) rises++;
         prev = spi_if.CS;
      end
      chk("frames_to_valid", rises, 4);
      chk("cur_full_scale", int'(current), 2047);
      chk("raw_fff", int'(raw), 12'hFFF);
      chk("ferr_ffff", int'(frame_error), 1);

      // minimum sample period: back-to-back frames, fixed CS-high gap
      for (int k = 0; k < 2; k++) begin
         wait_cs(1'b0, 400, n);
         wait_cs(1'b1, 400, lo);
         wait_cs(1'b0, 400, gap);
         chk("gap_cs_high", gap, 24);
         chk("start_to_start", lo + gap, 288);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
